// File: rtl/icache_burst_reader_if.sv
// Read-only burst bus between the instruction-cache burst reader and memory.
//
// Signals:
//   ar_valid / ar_ready : read-address handshake
//   ar_addr             : aligned burst byte address (BUS_ADDR_W bits)
//   ar_len              : beats minus one
//   r_valid / r_ready   : read-data handshake
//   r_data              : 32-bit read word
//   r_last              : last beat of the burst as signalled by memory
//   r_err               : per-beat error flag
//
// Modports:
//   master : the burst reader (drives address channel and r_ready)
//   slave  : the memory side
interface icache_burst_reader_if #(
    parameter int BUS_ADDR_W = 32
);
    logic                  ar_valid;
    logic                  ar_ready;
    logic [BUS_ADDR_W-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic                  r_valid;
    logic                  r_ready;
    logic [31:0]           r_data;
    logic                  r_last;
    logic                  r_err;

    modport master (
        output ar_valid, ar_addr, ar_len, r_ready,
        input  ar_ready, r_valid, r_data, r_last, r_err
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, r_ready,
        output ar_ready, r_valid, r_data, r_last, r_err
    );
endinterface

// File: rtl/icache_burst_reader.sv
// Instruction-cache line-fill burst reader.
//
// Accepts one line-fill request at a time, issues one aligned incrementing
// burst on the read bus and streams the returned words to the cache as a
// registered rvalid/rdata train. Exactly rlen+1 words are delivered per
// accepted request: a short burst is padded with PAD_WORD, extra beats of a
// long burst are drained and discarded. Any bus anomaly sets sticky bus_error.
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   request/addr/rlen  : line-fill request (held until ack), word address,
//                        burst length minus one (rlen+1 a power of two)
//   ack                : single-cycle acceptance, coincides with the
//                        address handshake
//   rvalid/rdata       : fill word stream, never back-pressured
//   bus                : read bus (master modport)
//   bus_error          : sticky error flag
module icache_burst_reader #(
    parameter int          LINE_W     = 8,
    parameter int          BUS_ADDR_W = 32,
    parameter logic [31:0] PAD_WORD   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic [29:0] addr,
    input  logic [4:0]  rlen,
    output logic        ack,
    output logic        rvalid,
    output logic [31:0] rdata,
    icache_burst_reader_if.master bus,
    output logic        bus_error
);

    // Bursts longer than a cache line are not meaningful; lengths are
    // confined to the line so the beat counter never runs past it.
    localparam logic [4:0] LEN_MASK = 5'(LINE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_PAD,
        S_DRAIN
    } state_t;

    state_t                state_q,     state_d;
    logic                  ar_valid_q,  ar_valid_d;
    logic [BUS_ADDR_W-1:0] ar_addr_q,   ar_addr_d;
    logic [4:0]            rlen_q,      rlen_d;
    logic [4:0]            cnt_q,       cnt_d;
    logic                  r_ready_q,   r_ready_d;
    logic                  rvalid_q,    rvalid_d;
    logic [31:0]           rdata_q,     rdata_d;
    logic                  bus_error_q, bus_error_d;

    logic                  beat;

    function automatic logic [4:0] clamp_len(input logic [4:0] len);
        return len & LEN_MASK;
    endfunction

    // rlen+1 is a power of two, so rlen itself is the mask of the low
    // word-address bits to clear. Byte address is then resized to the bus
    // width (BUS_ADDR_W up to 64).
    function automatic logic [BUS_ADDR_W-1:0] align_addr(input logic [29:0] wa,
                                                         input logic [4:0]  len);
        logic [29:0] aligned;
        logic [63:0] wide;
        aligned = wa & ~{25'b0, len};
        wide    = {32'b0, aligned, 2'b00};
        return wide[BUS_ADDR_W-1:0];
    endfunction

    assign beat = bus.r_valid & r_ready_q;

    always_comb begin
        state_d     = state_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;
        rlen_d      = rlen_q;
        cnt_d       = cnt_q;
        r_ready_d   = r_ready_q;
        rvalid_d    = 1'b0;
        rdata_d     = rdata_q;
        bus_error_d = bus_error_q;

        case (state_q)
            S_IDLE: begin
                if (request) begin
                    rlen_d     = clamp_len(rlen);
                    ar_addr_d  = align_addr(addr, clamp_len(rlen));
                    ar_valid_d = 1'b1;
                    cnt_d      = 5'd0;
                    state_d    = S_ADDR;
                end
            end

            S_ADDR: begin
                if (bus.ar_ready) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = S_DATA;
                end
            end

            S_DATA: begin
                if (beat) begin
                    rvalid_d = 1'b1;
                    rdata_d  = bus.r_data;
                    if (bus.r_err) begin
                        bus_error_d = 1'b1;
                    end
                    if (cnt_q == rlen_q) begin
                        if (bus.r_last) begin
                            r_ready_d = 1'b0;
                            state_d   = S_IDLE;
                        end else begin
                            // Memory overran the burst: keep accepting and
                            // discarding until it finally signals r_last.
                            bus_error_d = 1'b1;
                            state_d     = S_DRAIN;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                        if (bus.r_last) begin
                            bus_error_d = 1'b1;
                            r_ready_d   = 1'b0;
                            state_d     = S_PAD;
                        end
                    end
                end
            end

            // cnt_q is the index of the word being padded this cycle.
            S_PAD: begin
                rvalid_d = 1'b1;
                rdata_d  = PAD_WORD;
                if (cnt_q == rlen_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_DRAIN: begin
                if (beat) begin
                    if (bus.r_err) begin
                        bus_error_d = 1'b1;
                    end
                    if (bus.r_last) begin
                        r_ready_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            rlen_q      <= 5'd0;
            cnt_q       <= 5'd0;
            r_ready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= 32'd0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            rlen_q      <= rlen_d;
            cnt_q       <= cnt_d;
            r_ready_q   <= r_ready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

    // ack is the address handshake itself, so it can only occur in ADDR.
    assign ack          = (state_q == S_ADDR) & ar_valid_q & bus.ar_ready;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign bus_error    = bus_error_q;
    assign bus.ar_valid = ar_valid_q;
    assign bus.ar_addr  = ar_addr_q;
    assign bus.ar_len   = {3'b000, rlen_q};
    assign bus.r_ready  = r_ready_q;

endmodule

// File: tb/tb_icache_burst_reader.sv
module tb_icache_burst_reader;

    localparam logic [31:0] PAD = 32'h0000_0013;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        request = 1'b0;
    logic [29:0] addr    = '0;
    logic [4:0]  rlen    = '0;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        bus_error;

    icache_burst_reader_if #(.BUS_ADDR_W(32)) bus_if ();

    icache_burst_reader #(
        .LINE_W     (8),
        .BUS_ADDR_W (32),
        .PAD_WORD   (PAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .addr      (addr),
        .rlen      (rlen),
        .ack       (ack),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .bus       (bus_if),
        .bus_error (bus_error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_q[$];
    int          ack_cnt = 0;

    // Every delivered fill word, in order.
    always @(negedge clk) begin
        if (rvalid) got_q.push_back(rdata);
    end

    always @(posedge clk) begin
        if (ack) ack_cnt++;
    end

    typedef struct {
        logic [29:0] addr;
        logic [4:0]  rlen;
        int          delay;
        bit          gap;
        logic [31:0] base;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ack"},       32'(ack), 32'd0);
        chk({tag, "_rvalid"},    32'(rvalid), 32'd0);
        chk({tag, "_rdata"},     rdata, 32'd0);
        chk({tag, "_ar_valid"},  32'(bus_if.ar_valid), 32'd0);
        chk({tag, "_r_ready"},   32'(bus_if.r_ready), 32'd0);
        chk({tag, "_bus_error"}, 32'(bus_error), 32'd0);
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_zero_outputs(tag);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Request, wait for ar_valid, hold ar_ready low 'delay' cycles, handshake.
    task automatic addr_phase(input logic [29:0] a, input logic [4:0] l, input int delay,
                              input logic [31:0] exp_addr, input logic [7:0] exp_len);
        int n;
        n = 0;
        request = 1'b1;
        addr    = a;
        rlen    = l;
        @(negedge clk);
        while (!bus_if.ar_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("ar_valid_seen", 32'(bus_if.ar_valid), 32'd1);
        chk("ar_addr", bus_if.ar_addr, exp_addr);
        chk("ar_len", 32'(bus_if.ar_len), 32'(exp_len));
        for (int d = 0; d < delay; d++) begin
            chk("ar_valid_hold", 32'(bus_if.ar_valid), 32'd1);
            chk("ar_addr_hold", bus_if.ar_addr, exp_addr);
            chk("ack_while_waiting", 32'(ack), 32'd0);
            @(negedge clk);
        end
        bus_if.ar_ready = 1'b1;
        #1;
        chk("ack_handshake", 32'(ack), 32'd1);
        @(posedge clk); #1;
        request         = 1'b0;
        bus_if.ar_ready = 1'b0;
    endtask

    // Drive nb bus beats with data base+i; r_last on last_idx, r_err on err_idx.
    task automatic beats(input int nb, input logic [31:0] base, input int last_idx,
                         input int err_idx, input bit gap);
        for (int i = 0; i < nb; i++) begin
            if (gap && (i % 2 == 1)) begin
                bus_if.r_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus_if.r_valid = 1'b1;
            bus_if.r_data  = base + 32'(i);
            bus_if.r_last  = (i == last_idx);
            bus_if.r_err   = (i == err_idx);
            @(negedge clk);
            chk("r_ready_beat", 32'(bus_if.r_ready), 32'd1);
            @(posedge clk); #1;
        end
        bus_if.r_valid = 1'b0;
        bus_if.r_last  = 1'b0;
        bus_if.r_err   = 1'b0;
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Expect nreal words base+i followed by npad PAD words since index start.
    task automatic check_stream(input string name, input int start, input logic [31:0] base,
                                input int nreal, input int npad);
        chk({name, "_count"}, 32'(got_q.size() - start), 32'(nreal + npad));
        for (int i = 0; i < nreal + npad; i++) begin
            if (start + i < got_q.size())
                chk(name, got_q[start + i], (i < nreal) ? base + 32'(i) : PAD);
        end
    endtask

    initial begin
        int s;
        int a0;

        vecs[0] = '{30'h0000_0105, 5'd7, 0, 1'b0, 32'h0000_00A0, 32'h0000_0400, 8'd7};
        vecs[1] = '{30'h0000_0105, 5'd7, 5, 1'b0, 32'h0000_0100, 32'h0000_0400, 8'd7};
        vecs[2] = '{30'h3FFF_FFFF, 5'd3, 0, 1'b1, 32'h0000_0200, 32'hFFFF_FFF0, 8'd3};
        vecs[3] = '{30'h0000_1237, 5'd0, 2, 1'b0, 32'h0000_0300, 32'h0000_48DC, 8'd0};
        vecs[4] = '{30'h2AAA_AAAB, 5'd1, 0, 1'b1, 32'h0000_0400, 32'hAAAA_AAA8, 8'd1};
        vecs[5] = '{30'h0000_00FF, 5'd7, 1, 1'b1, 32'h0000_0500, 32'h0000_03E0, 8'd7};

        bus_if.ar_ready = 1'b0;
        bus_if.r_valid  = 1'b0;
        bus_if.r_data   = 32'd0;
        bus_if.r_last   = 1'b0;
        bus_if.r_err    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst = 1'b1;

        // Well-behaved fills from the table
        foreach (vecs[k]) begin
            s  = got_q.size();
            a0 = ack_cnt;
            addr_phase(vecs[k].addr, vecs[k].rlen, vecs[k].delay, vecs[k].exp_addr, vecs[k].exp_len);
            beats(int'(vecs[k].rlen) + 1, vecs[k].base, int'(vecs[k].rlen), -1, vecs[k].gap);
            settle();
            check_stream("fill_data", s, vecs[k].base, int'(vecs[k].rlen) + 1, 0);
            chk("fill_ack_count", 32'(ack_cnt - a0), 32'd1);
            chk("fill_bus_error", 32'(bus_error), 32'd0);
        end

        // r_err on one beat: data still forwarded, bus_error sticky
        s = got_q.size();
        addr_phase(30'h0000_0020, 5'd3, 0, 32'h0000_0080, 8'd3);
        beats(4, 32'h0000_0B00, 3, 1, 1'b0);
        settle();
        check_stream("rerr_data", s, 32'h0000_0B00, 4, 0);
        chk("rerr_bus_error", 32'(bus_error), 32'd1);
        do_reset("rerr_reset");

        // Short burst: 4 bus words then 4 pad words
        s = got_q.size();
        addr_phase(30'h0000_0105, 5'd7, 0, 32'h0000_0400, 8'd7);
        beats(4, 32'h0000_00A0, 3, -1, 1'b0);
        @(negedge clk);
        chk("short_r_ready_pad", 32'(bus_if.r_ready), 32'd0);
        @(posedge clk); #1;
        settle();
        check_stream("short_data", s, 32'h0000_00A0, 4, 4);
        chk("short_bus_error", 32'(bus_error), 32'd1);
        do_reset("short_reset");

        // Long burst: 7 bus beats, only 4 delivered, then a normal request
        s  = got_q.size();
        a0 = ack_cnt;
        addr_phase(30'h0000_0030, 5'd3, 1, 32'h0000_00C0, 8'd3);
        beats(7, 32'h0000_0C00, 6, -1, 1'b0);
        settle();
        check_stream("long_data", s, 32'h0000_0C00, 4, 0);
        chk("long_bus_error", 32'(bus_error), 32'd1);
        s = got_q.size();
        addr_phase(30'h0000_0010, 5'd1, 0, 32'h0000_0040, 8'd1);
        beats(2, 32'h0000_0D00, 1, -1, 1'b0);
        settle();
        check_stream("after_long_data", s, 32'h0000_0D00, 2, 0);
        chk("long_ack_count", 32'(ack_cnt - a0), 32'd2);

        // Mid-burst reset after 2 of 8 beats have been delivered
        do_reset("pre_mid_reset");
        s = got_q.size();
        addr_phase(30'h0000_0105, 5'd7, 0, 32'h0000_0400, 8'd7);
        beats(2, 32'h0000_0E00, -1, -1, 1'b0);
        @(posedge clk); #1;
        chk("mid_r_ready_before", 32'(bus_if.r_ready), 32'd1);
        do_reset("mid_reset");
        settle();
        check_stream("mid_data", s, 32'h0000_0E00, 2, 0);
        s = got_q.size();
        addr_phase(30'h0000_0040, 5'd3, 0, 32'h0000_0100, 8'd3);
        beats(4, 32'h0000_0F00, 3, -1, 1'b0);
        settle();
        check_stream("fresh_data", s, 32'h0000_0F00, 4, 0);
        chk("fresh_bus_error", 32'(bus_error), 32'd0);

        // Back-to-back: second request raised as the final beat's rvalid appears
        s  = got_q.size();
        a0 = ack_cnt;
        addr_phase(30'h0000_0008, 5'd3, 0, 32'h0000_0020, 8'd3);
        beats(4, 32'h0000_0050, 3, -1, 1'b0);
        request = 1'b1;
        addr    = 30'h0000_000C;
        rlen    = 5'd3;
        @(negedge clk);
        chk("b2b_final_rvalid", 32'(rvalid), 32'd1);
        chk("b2b_final_rdata", rdata, 32'h0000_0053);
        chk("b2b_ar_valid_not_yet", 32'(bus_if.ar_valid), 32'd0);
        @(negedge clk);
        chk("b2b_ar_valid_next", 32'(bus_if.ar_valid), 32'd1);
        chk("b2b_rvalid_gap", 32'(rvalid), 32'd0);
        addr_phase(30'h0000_000C, 5'd3, 0, 32'h0000_0030, 8'd3);
        beats(4, 32'h0000_0060, 3, -1, 1'b0);
        settle();
        chk("b2b_count", 32'(got_q.size() - s), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (s + i < got_q.size())
                chk("b2b_data", got_q[s + i],
                    (i < 4) ? 32'h0000_0050 + 32'(i) : 32'h0000_0060 + 32'(i - 4));
        end
        chk("b2b_ack_count", 32'(ack_cnt - a0), 32'd2);
        chk("b2b_bus_error", 32'(bus_error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
